// File: rtl/aes_pkg.sv
// Shared definitions for the AES stream sequencer: command/klen codes,
// status bit layout and the sequencer state encoding.
package aes_pkg;

    localparam logic [1:0] CMD_LOAD_KEY = 2'd0;
    localparam logic [1:0] CMD_ENCRYPT  = 2'd1;
    localparam logic [1:0] CMD_DECRYPT  = 2'd2;

    localparam logic [1:0] KLEN_128 = 2'd0;
    localparam logic [1:0] KLEN_192 = 2'd1;
    localparam logic [1:0] KLEN_256 = 2'd2;

    localparam int ST_KEY_VALID  = 0;
    localparam int ST_BUSY       = 1;
    localparam int ST_KEY_DONE   = 2;
    localparam int ST_BURST_DONE = 3;
    localparam int ST_ERR        = 4;
    localparam int ST_KLEN_LO    = 5;
    localparam int ST_KLEN_HI    = 6;

    localparam logic [31:0] ST_KEY_VALID_M  = 32'h0000_0001;
    localparam logic [31:0] ST_BUSY_M       = 32'h0000_0002;
    localparam logic [31:0] ST_KEY_DONE_M   = 32'h0000_0004;
    localparam logic [31:0] ST_BURST_DONE_M = 32'h0000_0008;
    localparam logic [31:0] ST_ERR_M        = 32'h0000_0010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEY_EXP = 3'd1,
        S_WAIT_IN = 3'd2,
        S_CORE    = 3'd3,
        S_OUT     = 3'd4
    } state_e;

    // Number of AES rounds for a given key-length code.
    function automatic logic [3:0] klen_rounds(input logic [1:0] klen);
        case (klen)
            KLEN_192: return 4'd12;
            KLEN_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_cbc_chain.sv
// CBC chaining register with the pre-core XOR (encrypt) and post-core XOR
// (decrypt) muxing; ECB bypasses both and leaves the register untouched.
module aes_cbc_chain
    import aes_pkg::*;
#(
    parameter int BLK_S = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_iv_i,
    input  logic [BLK_S-1:0] iv_i,
    input  logic             cbc_i,
    input  logic             dec_i,
    input  logic             update_i,
    input  logic [BLK_S-1:0] blk_in_i,
    input  logic [BLK_S-1:0] core_out_i,
    output logic [BLK_S-1:0] core_in_o,
    output logic [BLK_S-1:0] result_o
);

    logic [BLK_S-1:0] chain_q, chain_d;

    // Decrypt chains on the ciphertext that went in, encrypt on what came out.
    always_comb begin
        chain_d = chain_q;
        if (load_iv_i)
            chain_d = iv_i;
        else if (update_i && cbc_i)
            chain_d = dec_i ? blk_in_i : core_out_i;
    end

    always_ff @(posedge clk) begin
        if (reset) chain_q <= '0;
        else       chain_q <= chain_d;
    end

    assign core_in_o = (cbc_i && !dec_i) ? (blk_in_i ^ chain_q) : blk_in_i;
    assign result_o  = (cbc_i && dec_i)  ? (core_out_i ^ chain_q) : core_out_i;

endmodule

// File: rtl/aes_stream_ctrl.sv
// AES top-level sequencer: command decode, key-expansion and round-core
// start/done handshakes, single-buffered block streaming and status.
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter int BLK_S    = 128,
    parameter int KEY_S    = 256,
    parameter int CNT_W    = 16,
    parameter int STATUS_S = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    input  logic                cmd_cbc,
    input  logic [1:0]          cmd_klen,
    input  logic [KEY_S-1:0]    key,
    input  logic [BLK_S-1:0]    iv,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK_S-1:0]    in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLK_S-1:0]    out_data,
    output logic                out_last,
    output logic                ke_start,
    output logic [1:0]          ke_klen,
    output logic [KEY_S-1:0]    ke_key,
    input  logic                ke_done,
    output logic                core_start,
    output logic                core_dec,
    output logic [BLK_S-1:0]    core_in,
    input  logic [BLK_S-1:0]    core_out,
    input  logic                core_done,
    output logic [STATUS_S-1:0] status,
    output logic [CNT_W-1:0]    blk_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e state_q, state_d;

    logic [KEY_S-1:0] key_q;
    logic [1:0]       klen_q;
    logic             key_valid_q, cbc_q, dec_q, last_q, out_last_q;
    logic [BLK_S-1:0] data_q, out_data_q, chain_result;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             key_done_q, burst_done_q, err_q;
    logic             ke_start_q, core_start_q;

    logic cmd_acc, load_ok, run_ok, cmd_err, stray_cmd;
    logic ke_hit, in_hs, core_hit, out_hs;

    assign cmd_acc   = cmd_valid && (state_q == S_IDLE);
    assign stray_cmd = cmd_valid && (state_q != S_IDLE);
    assign load_ok   = cmd_acc && (cmd == CMD_LOAD_KEY) && (cmd_klen != 2'd3);
    assign run_ok    = cmd_acc && ((cmd == CMD_ENCRYPT) || (cmd == CMD_DECRYPT)) && key_valid_q;
    assign cmd_err   = cmd_acc && !load_ok && !run_ok;
    assign ke_hit    = ke_done && (state_q == S_KEY_EXP);
    assign in_hs     = in_valid && (state_q == S_WAIT_IN);
    assign core_hit  = core_done && (state_q == S_CORE);
    assign out_hs    = out_ready && (state_q == S_OUT);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_ok)     state_d = S_KEY_EXP;
                else if (run_ok) state_d = S_WAIT_IN;
            end
            S_KEY_EXP: if (ke_done)   state_d = S_IDLE;
            S_WAIT_IN: if (in_valid)  state_d = S_CORE;
            S_CORE:    if (core_done) state_d = S_OUT;
            S_OUT:     if (out_ready) state_d = out_last_q ? S_IDLE : S_WAIT_IN;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        status    = '0;
        in_ready  = (state_q == S_WAIT_IN);
        out_valid = (state_q == S_OUT);
        status[ST_KEY_VALID]          = key_valid_q;
        status[ST_BUSY]               = (state_q != S_IDLE);
        status[ST_KEY_DONE]           = key_done_q;
        status[ST_BURST_DONE]         = burst_done_q;
        status[ST_ERR]                = err_q;
        status[ST_KLEN_HI:ST_KLEN_LO] = klen_q;
    end

    // Start pulses are registered so they appear in the first cycle of the wait state.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q        <= '0;
            klen_q       <= '0;
            key_valid_q  <= 1'b0;
            cbc_q        <= 1'b0;
            dec_q        <= 1'b0;
            data_q       <= '0;
            last_q       <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            blk_cnt_q    <= '0;
            key_done_q   <= 1'b0;
            burst_done_q <= 1'b0;
            err_q        <= 1'b0;
            ke_start_q   <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            ke_start_q   <= load_ok;
            core_start_q <= in_hs;
            if (load_ok) begin
                key_q       <= key;
                klen_q      <= cmd_klen;
                key_valid_q <= 1'b0;
            end else if (ke_hit) begin
                key_valid_q <= 1'b1;
            end
            if (run_ok) begin
                cbc_q     <= cmd_cbc;
                dec_q     <= (cmd == CMD_DECRYPT);
                blk_cnt_q <= '0;
            end
            if (in_hs) begin
                data_q <= in_data;
                last_q <= in_last;
            end
            if (core_hit) begin
                out_data_q <= chain_result;
                out_last_q <= last_q;
            end
            if (out_hs && !(&blk_cnt_q))
                blk_cnt_q <= blk_cnt_q + CNT_ONE;
            if (cmd_acc) begin
                key_done_q   <= 1'b0;
                burst_done_q <= 1'b0;
                err_q        <= 1'b0;
            end
            if (ke_hit)                key_done_q   <= 1'b1;
            if (out_hs && out_last_q)  burst_done_q <= 1'b1;
            if (cmd_err || stray_cmd)  err_q        <= 1'b1;
        end
    end

    aes_cbc_chain #(.BLK_S(BLK_S)) u_chain (
        .clk        (clk),
        .reset      (reset),
        .load_iv_i  (run_ok),
        .iv_i       (iv),
        .cbc_i      (cbc_q),
        .dec_i      (dec_q),
        .update_i   (core_hit),
        .blk_in_i   (data_q),
        .core_out_i (core_out),
        .core_in_o  (core_in),
        .result_o   (chain_result)
    );

    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign ke_start   = ke_start_q;
    assign ke_klen    = klen_q;
    assign ke_key     = key_q;
    assign core_start = core_start_q;
    assign core_dec   = dec_q;
    assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with known-answer key-expansion and core
// responders and a queue-based output scoreboard.
module tb_aes_stream_ctrl;
    import aes_pkg::*;

    localparam int BLK_S    = 128;
    localparam int KEY_S    = 256;
    localparam int CNT_W    = 16;
    localparam int STATUS_S = 32;

    localparam logic [255:0] K0    = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KNIST = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT0     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT0_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] IV0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1      = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1      = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2      = 128'h5086cb9b507219ee95db113a917678b2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic [1:0]          cmd = '0;
    logic                cmd_cbc = 1'b0;
    logic [1:0]          cmd_klen = '0;
    logic [KEY_S-1:0]    key = '0;
    logic [BLK_S-1:0]    iv = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [BLK_S-1:0]    in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [BLK_S-1:0]    out_data;
    logic                out_last;
    logic                ke_start;
    logic [1:0]          ke_klen;
    logic [KEY_S-1:0]    ke_key;
    logic                ke_done = 1'b0;
    logic                core_start;
    logic                core_dec;
    logic [BLK_S-1:0]    core_in;
    logic [BLK_S-1:0]    core_out = '0;
    logic                core_done = 1'b0;
    logic [STATUS_S-1:0] status;
    logic [CNT_W-1:0]    blk_cnt;

    always #5 clk = ~clk;

    aes_stream_ctrl #(.BLK_S(BLK_S), .KEY_S(KEY_S), .CNT_W(CNT_W), .STATUS_S(STATUS_S)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_cbc(cmd_cbc),
        .cmd_klen(cmd_klen), .key(key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .ke_start(ke_start), .ke_klen(ke_klen),
        .ke_key(ke_key), .ke_done(ke_done), .core_start(core_start), .core_dec(core_dec),
        .core_in(core_in), .core_out(core_out), .core_done(core_done), .status(status),
        .blk_cnt(blk_cnt)
    );

    int               n_checks = 0;
    int               n_pass = 0;
    int               core_starts = 0;
    logic [BLK_S:0]   exp_q[$];
    logic [KEY_S-1:0] seen_key = '0;
    logic [1:0]       seen_klen = '0;
    logic [BLK_S-1:0] core_res;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Known-answer stand-in for the FIPS-197 cipher; unknown inputs give a wrong answer.
    function automatic logic [127:0] core_model(input logic [255:0] k, input logic dec,
                                                input logic [127:0] d);
        logic [127:0] r;
        r = ~d;
        if (!dec && k == K0 && d == PT0)             r = CT0_128;
        else if (!dec && k == K256 && d == PT0)      r = CT0_256;
        else if (!dec && k == KNIST && d == (P1 ^ IV0)) r = C1;
        else if (!dec && k == KNIST && d == (P2 ^ C1))  r = C2;
        else if (dec && k == KNIST && d == C1)       r = P1 ^ IV0;
        else if (dec && k == KNIST && d == C2)       r = P2 ^ C1;
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (ke_start) begin
                seen_key  = ke_key;
                seen_klen = ke_klen;
                repeat (3) @(negedge clk);
                ke_done = 1'b1;
                @(negedge clk);
                ke_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (core_start) begin
                core_starts++;
                core_res = core_model(seen_key, core_dec, core_in);
                repeat (3) @(negedge clk);
                core_out  = core_res;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                core_out  = '0;
            end
        end
    end

    initial begin
        logic [BLK_S:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {out_last, out_data}, '1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_block", {out_last, out_data}, e);
                end
            end
        end
    end

    task automatic issue_cmd(input logic [1:0] c, input logic cbc, input logic [1:0] kl,
                             input logic [255:0] k, input logic [127:0] v);
        cmd_valid = 1'b1; cmd = c; cmd_cbc = cbc; cmd_klen = kl; key = k; iv = v;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!status[ST_BUSY]) begin done = 1'b1; break; end
            @(negedge clk);
        end
        check(name, done, 1'b1);
    endtask

    task automatic send_block(input logic [127:0] d, input logic last, input logic [127:0] exp);
        logic ok;
        ok = 1'b0;
        exp_q.push_back({last, exp});
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("in_accept", ok, 1'b1);
    endtask

    task automatic load_key(input logic [1:0] kl, input logic [255:0] k);
        issue_cmd(CMD_LOAD_KEY, 1'b0, kl, k, '0);
        wait_idle("key_exp_idle");
        check("ke_key", seen_key, k);
        check("ke_klen", seen_klen, kl);
    endtask

    initial begin
        logic [BLK_S-1:0] held;
        logic             got, seen_out;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_status", status, '0);
        check("rst_handshake", {in_ready, out_valid, out_last, ke_start, core_start, core_dec}, '0);
        check("rst_data", {out_data, core_in}, '0);
        check("rst_key", {ke_key, ke_klen, blk_cnt}, '0);

        // Encrypt without a key.
        issue_cmd(CMD_ENCRYPT, 1'b0, 2'd0, '0, '0);
        repeat (4) @(negedge clk);
        check("nokey_status", status, ST_ERR_M);
        check("nokey_core_starts", core_starts, 0);

        load_key(KLEN_128, K0);
        check("key128_status", status, ST_KEY_VALID_M | ST_KEY_DONE_M);

        issue_cmd(2'd3, 1'b0, 2'd0, '0, '0);
        check("reserved_status", status, ST_KEY_VALID_M | ST_ERR_M);

        issue_cmd(CMD_ENCRYPT, 1'b0, 2'd0, '0, '0);
        send_block(PT0, 1'b1, CT0_128);
        wait_idle("ecb128_idle");
        check("ecb128_blk_cnt", blk_cnt, 1);
        check("ecb128_status", status, ST_KEY_VALID_M | ST_BURST_DONE_M);

        load_key(KLEN_128, KNIST);
        issue_cmd(CMD_ENCRYPT, 1'b1, 2'd0, '0, IV0);
        send_block(P1, 1'b0, C1);
        issue_cmd(CMD_LOAD_KEY, 1'b0, 2'd0, K0, '0);
        send_block(P2, 1'b1, C2);
        wait_idle("cbc_enc_idle");
        check("cbc_enc_blk_cnt", blk_cnt, 2);
        check("cbc_enc_status", status, ST_KEY_VALID_M | ST_BURST_DONE_M | ST_ERR_M);

        // Decrypt with an output stall on the first block.
        out_ready = 1'b0;
        issue_cmd(CMD_DECRYPT, 1'b1, 2'd0, '0, IV0);
        send_block(C1, 1'b0, P1);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("stall_out_valid_seen", got, 1'b1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data", out_data, held);
            check("stall_ready", {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        send_block(C2, 1'b1, P2);
        wait_idle("cbc_dec_idle");
        check("cbc_dec_blk_cnt", blk_cnt, 2);
        check("cbc_dec_status", status, ST_KEY_VALID_M | ST_BURST_DONE_M);

        load_key(KLEN_256, K256);
        check("key256_status", status, ST_KEY_VALID_M | ST_KEY_DONE_M | 32'h40);
        issue_cmd(CMD_ENCRYPT, 1'b0, 2'd0, '0, '0);
        send_block(PT0, 1'b1, CT0_256);
        wait_idle("ecb256_idle");
        check("ecb256_status", status, ST_KEY_VALID_M | ST_BURST_DONE_M | 32'h40);

        // Reset while the core is busy; its late done must be ignored.
        issue_cmd(CMD_ENCRYPT, 1'b0, 2'd0, '0, '0);
        in_valid = 1'b1; in_data = PT0; in_last = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rstcore_accept", {got, core_start}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen_out = 1'b1;
        end
        check("rstcore_no_out", seen_out, 1'b0);
        check("rstcore_status", status, '0);
        check("rstcore_outs", {in_ready, out_last, ke_start, core_start, core_dec, blk_cnt}, '0);
        check("rstcore_data", {out_data, core_in}, '0);
        check("rstcore_key", {ke_key, ke_klen}, '0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
